// File: rtl/dcache_wt_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines,
// a whole-cache flush sequencer and saturating read hit/miss counters.
module dcache_wt_dm #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LINES   = 16,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_re,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_stall,
  input  logic               flush,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, RD, WR, FLUSH} state_t;

  state_t              state, state_n;
  logic                flush_pending;
  logic [IDX_W-1:0]    fcnt;
  logic [DATA_W-1:0]   rdata_q, rdata_c;
  logic                stall_c, req_c, we_c, hit_inc, miss_inc;

  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    tags [LINES];
  logic [DATA_W-1:0]   data [LINES];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;

  assign idx = cpu_addr[IDX_W+1:2];
  assign tag = cpu_addr[ADDR_W-1:IDX_W+2];
  assign hit = valid[idx] && (tags[idx] == tag);

  assign mem_addr  = cpu_addr & ~ADDR_W'(3);
  assign mem_wdata = cpu_wdata;

  always_comb begin
    state_n  = state;
    stall_c  = 1'b0;
    req_c    = 1'b0;
    we_c     = 1'b0;
    rdata_c  = rdata_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    case (state)
      IDLE: begin
        if (flush || flush_pending) begin
          state_n = FLUSH;
          stall_c = cpu_re | cpu_we;
        end else if (cpu_we) begin
          stall_c = 1'b1;
          state_n = WR;
        end else if (cpu_re) begin
          if (hit) begin
            rdata_c = data[idx];
            hit_inc = 1'b1;
          end else begin
            stall_c  = 1'b1;
            state_n  = RD;
            miss_inc = 1'b1;
          end
        end
      end
      RD: begin
        req_c   = 1'b1;
        stall_c = ~mem_ack;
        if (mem_ack) begin
          rdata_c = mem_rdata;
          state_n = IDLE;
        end
      end
      WR: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        stall_c = ~mem_ack;
        if (mem_ack) state_n = IDLE;
      end
      FLUSH: begin
        stall_c = 1'b1;
        if (fcnt == IDX_W'(LINES - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an abandoned transaction drops at once.
  assign cpu_stall = reset & stall_c;
  assign mem_req   = reset & req_c;
  assign mem_we    = reset & we_c;
  assign cpu_rdata = reset ? rdata_c : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      fcnt          <= '0;
      valid         <= '0;
      rdata_q       <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      state   <= state_n;
      rdata_q <= rdata_c;
      case (state)
        IDLE: begin
          if (flush || flush_pending) begin
            flush_pending <= 1'b0;
            fcnt          <= '0;
          end
        end
        RD: begin
          if (flush) flush_pending <= 1'b1;
          if (mem_ack) valid[idx] <= 1'b1;
        end
        WR: begin
          if (flush) flush_pending <= 1'b1;
        end
        FLUSH: begin
          valid[fcnt] <= 1'b0;
          fcnt        <= fcnt + IDX_W'(1);
        end
        default: ;
      endcase
      if (hit_inc && hit_count != '1)   hit_count  <= hit_count + COUNT_W'(1);
      if (miss_inc && miss_count != '1) miss_count <= miss_count + COUNT_W'(1);
    end
  end

  // Tag/data arrays carry no reset; validity is tracked solely by the valid bits.
  always_ff @(posedge clk) begin
    if (state == RD && mem_ack) begin
      tags[idx] <= tag;
      data[idx] <= mem_rdata;
    end else if (state == WR && mem_ack && hit) begin
      data[idx] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_wt_dm.sv
// Directed self-checking bench for dcache_wt_dm with a configurable-latency memory responder.
module tb_dcache_wt_dm;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we, flush;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  hit_count, miss_count;

  int          checks = 0;
  int          failures = 0;
  int          lat = 2;
  int          wc = 0;
  int          acks = 0;
  logic [31:0] rd_val = '0;

  dcache_wt_dm #(.ADDR_W(32), .DATA_W(32), .LINES(16), .COUNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Memory acknowledges lat cycles after the first cycle of mem_req.
  assign mem_rdata = rd_val;
  assign mem_ack   = mem_req && (wc == lat);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wc <= 0;
    else                     wc <= wc + 1;
    if (mem_req && mem_ack) acks <= acks + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls,
                        output logic [31:0] rdata, output logic saw_req, output logic saw_we,
                        output logic [31:0] req_addr, output logic [31:0] req_wdata);
    logic done;
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    stalls = 0; rdata = 'x; saw_req = 1'b0; saw_we = 1'b0;
    req_addr = 'x; req_wdata = 'x; done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (mem_req && !saw_req) begin
        saw_req = 1'b1; saw_we = mem_we; req_addr = mem_addr; req_wdata = mem_wdata;
      end
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        done  = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
    end
    if (!done) chk("access_timeout", 32'(stalls), 32'd0);
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input int exp_st,
                        input logic [31:0] exp_d);
    int st; logic [31:0] d, ra, rw; logic sr, sw;
    access(1'b1, 1'b0, addr, '0, st, d, sr, sw, ra, rw);
    chk({tag, "_stalls"}, 32'(st), 32'(exp_st));
    chk({tag, "_rdata"}, d, exp_d);
  endtask

  task automatic flush_len(output int n);
    logic found;
    n = 0; found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (cpu_stall) begin found = 1'b1; break; end
      @(posedge clk);
    end
    if (found) begin
      for (int i = 0; i < 40; i++) begin
        if (!cpu_stall) break;
        n++;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int st, n, a0;
    logic [31:0] d, ra, rw;
    logic sr, sw;
    logic [3:0] h;

    reset = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; flush = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    #22;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_misses", 32'(miss_count), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic miss then hit.
    lat = 2; rd_val = 32'hDEADBEEF;
    rd_chk("miss40", 32'h40, 3, 32'hDEADBEEF);
    a0 = acks;
    rd_chk("hit40", 32'h40, 0, 32'hDEADBEEF);
    chk("hit40_noreq", 32'(acks), 32'(a0));
    chk("hit40_hits", 32'(hit_count), 32'd1);
    chk("hit40_misses", 32'(miss_count), 32'd1);

    // Asynchronous reset while a read is outstanding.
    lat = 10; cpu_re = 1'b1; cpu_addr = 32'h44;
    repeat (3) @(posedge clk);
    #2;
    chk("rd_req_before_rst", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_stall", 32'(cpu_stall), 32'd0);
    chk("arst_rdata", cpu_rdata, 32'd0);
    chk("arst_hits", 32'(hit_count), 32'd0);
    chk("arst_misses", 32'(miss_count), 32'd0);
    #1; cpu_re = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    lat = 2; rd_val = 32'h11112222;
    rd_chk("miss44_after_rst", 32'h44, 3, 32'h11112222);

    // Conflict misses on index 0.
    a0 = acks;
    rd_val = 32'hA0A0A0A0; rd_chk("conf40a", 32'h40, 3, 32'hA0A0A0A0);
    rd_val = 32'hB0B0B0B0; rd_chk("conf80",  32'h80, 3, 32'hB0B0B0B0);
    rd_val = 32'hC0C0C0C0; rd_chk("conf40b", 32'h40, 3, 32'hC0C0C0C0);
    chk("conf_reqs", 32'(acks - a0), 32'd3);
    chk("conf_misses", 32'(miss_count), 32'd4);

    // Write-through hit updates the line; write miss does not allocate.
    access(1'b0, 1'b1, 32'h40, 32'h12345678, st, d, sr, sw, ra, rw);
    chk("wr40_stalls", 32'(st), 32'd3);
    chk("wr40_req", 32'(sr), 32'd1);
    chk("wr40_we", 32'(sw), 32'd1);
    chk("wr40_addr", ra, 32'h40);
    chk("wr40_wdata", rw, 32'h12345678);
    rd_chk("hit40_after_wr", 32'h40, 0, 32'h12345678);
    chk("hits_after_wr", 32'(hit_count), 32'd1);
    access(1'b0, 1'b1, 32'hC2, 32'h0BAD0BAD, st, d, sr, sw, ra, rw);
    chk("wrC0_we", 32'(sw), 32'd1);
    chk("wrC0_addr", ra, 32'hC0);
    rd_chk("hit40_after_wrmiss", 32'h40, 0, 32'h12345678);
    rd_val = 32'h00000055;
    rd_chk("missC0_noalloc", 32'hC0, 3, 32'h00000055);
    chk("misses_after_wr", 32'(miss_count), 32'd5);

    // Fill four lines, flush, all four miss again.
    for (int i = 0; i < 4; i++) begin
      rd_val = 32'h200 + 32'(i) * 4 + 32'h1000;
      rd_chk("fill", 32'h200 + 32'(i) * 4, 3, rd_val);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    flush_len(n);
    chk("flush_len", 32'(n), 32'd16);
    for (int i = 0; i < 4; i++) begin
      rd_val = 32'h9000 + 32'(i);
      rd_chk("after_flush", 32'h200 + 32'(i) * 4, 3, rd_val);
    end
    chk("misses_after_flush", 32'(miss_count), 32'd13);

    // Flush pulse during a write: write completes, then full flush.
    lat = 4; a0 = acks; st = 0;
    cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    st = 1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    st++;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!cpu_stall) break;
      st++;
      @(posedge clk);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    chk("wrflush_stalls", 32'(st), 32'd5);
    chk("wrflush_acked", 32'(acks - a0), 32'd1);
    flush_len(n);
    chk("wrflush_len", 32'(n), 32'd16);

    // Simultaneous read and write is a write; then saturate the hit counter.
    lat = 2; rd_val = 32'h00000066;
    rd_chk("fill208", 32'h208, 3, 32'h00000066);
    h = hit_count;
    access(1'b1, 1'b1, 32'h208, 32'h00000077, st, d, sr, sw, ra, rw);
    chk("rewe_we", 32'(sw), 32'd1);
    chk("rewe_hits", 32'(hit_count), 32'(h));
    for (int i = 0; i < 20; i++) access(1'b1, 1'b0, 32'h208, '0, st, d, sr, sw, ra, rw);
    chk("sat_rdata", d, 32'h00000077);
    chk("sat_stalls", 32'(st), 32'd0);
    chk("sat_hits", 32'(hit_count), 32'd15);
    chk("sat_misses", 32'(miss_count), 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_wt_dm.md
Name: dcache_wt_dm

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache placed between the pipelined MIPS core's memory stage and a variable-latency backing data memory.
- Replaces the single-cycle dmem attachment: the core sees a stall output instead of fixed one-cycle access.
- Adds a whole-cache flush sequencer and saturating hit/miss counters for performance tests.

Parameters:
- ADDR_W, 32, byte address width; word aligned, bits [1:0] ignored.
- DATA_W, 32, data word width.
- LINES, 16, number of one-word lines; power of two, at least 2. IDX_W = log2(LINES).
- COUNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset: the block is reset while reset==0.
- cpu_re  in  1  core load request.
- cpu_we  in  1  core store request.
- cpu_addr  in  ADDR_W  core byte address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data; valid when cpu_re==1 and cpu_stall==0.
- cpu_stall  out  1  core must hold its request and freeze the pipeline.
- flush  in  1  single-cycle pulse requesting invalidation of every line.
- mem_req  out  1  backing memory request; held until mem_ack.
- mem_we  out  1  request is a write.
- mem_addr  out  ADDR_W  word address, equal to cpu_addr with bits [1:0] forced to 0.
- mem_wdata  out  DATA_W  write data (cpu_wdata).
- mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion strobe; may arrive in the same cycle as mem_req.
- hit_count  out  COUNT_W  saturating count of read hits.
- miss_count  out  COUNT_W  saturating count of read misses.

Behaviour:
- Address split:
  - index = cpu_addr[IDX_W+1:2]
  - tag = cpu_addr[ADDR_W-1:IDX_W+2]
- Per line storage: valid bit, tag, data.
- hit = valid[index] && tag matches.
- Reset (reset==0, asynchronous):
  - All valid bits cleared; state goes to IDLE; flush_pending cleared.
  - Counters return to 0.
  - mem_req, mem_we and cpu_stall are 0 immediately; cpu_rdata is 0.
  - An outstanding memory transaction is abandoned; any late mem_ack after reset is ignored.
- States: IDLE, RD, WR, FLUSH.
- IDLE:
  - Flush is handled first. If flush==1 or flush_pending==1, the block enters FLUSH, clears the index counter and asserts cpu_stall. Any access is deferred.
  - Else if cpu_we==1 (write takes priority over cpu_re when both are set), the block asserts cpu_stall and enters WR.
  - Else if cpu_re==1 and the access hits: cpu_rdata = line data combinationally, cpu_stall = 0, hit_count increments.
  - Else if cpu_re==1 and the access misses: cpu_stall = 1, enter RD, miss_count increments once.
  - Otherwise cpu_stall = 0. cpu_rdata holds its last value and is don't-care.
- RD:
  - Drives mem_req=1, mem_we=0.
  - cpu_stall = ~mem_ack.
  - In the ack cycle, cpu_rdata = mem_rdata. At that clock edge the line is filled (valid=1, tag, data) and the state returns to IDLE.
  - Miss latency = cycles until ack + 1 (IDLE decode cycle).
- WR:
  - Drives mem_req=1, mem_we=1.
  - cpu_stall = ~mem_ack.
  - At the ack edge: if the address hits, the line data is updated to cpu_wdata. On a miss, no allocation takes place. The state returns to IDLE.
- FLUSH:
  - Clears valid[counter] each cycle; counter runs 0..LINES-1.
  - cpu_stall = 1 throughout.
  - After clearing line LINES-1, the state returns to IDLE. Total flush = LINES cycles, plus the IDLE entry cycle if an access is waiting.
- flush arriving in RD or WR sets flush_pending. The in-flight transaction completes first, then FLUSH runs; flush_pending clears on FLUSH entry.
- flush arriving during FLUSH is absorbed: no restart.
- Counters saturate at 2^COUNT_W-1 with no wrap.
- Core inputs are sampled only in IDLE and must be held stable while cpu_stall==1. A changed request is not checked.
- The cycle in which the stall drops completes the access. The core presents its next request in the following cycle.
- mem_addr and mem_wdata are stable for the whole duration of mem_req.

Test Plan:
- Reset with reset=0 during RD with mem_req=1 -> mem_req=0 and cpu_stall=0 asynchronously. Counters are 0. A subsequent read of the same address misses.
- LINES=16, read 0x40, memory acks 2 cycles after mem_req with 0xDEADBEEF -> stall high for 3 cycles, low in the ack cycle with cpu_rdata=0xDEADBEEF. A second read of 0x40 gives stall=0, no mem_req, hit_count=1, miss_count=1.
- Conflict: read 0x40, read 0x80 (both index 0), then read 0x40 again -> three misses and three mem_req; miss_count=3.
- Fill 0x40, then write 0x40=0x12345678 -> mem_req=1, mem_we=1, mem_addr=0x40, mem_wdata=0x12345678. The next read of 0x40 hits with 0x12345678. Write 0xC0 (miss), then read 0xC0 -> miss, confirming no allocation.
- Fill 4 lines, pulse flush -> cpu_stall for exactly 16 cycles, after which all 4 addresses miss. Pulse flush during a WR -> the write completes first, then the 16-cycle flush runs.
- COUNT_W=4, 20 consecutive read hits -> hit_count=15 (saturated). A simultaneous cpu_re=cpu_we=1 is handled as a write (mem_we=1) and hit_count is unchanged.
